// File: rtl/add_acc_ctrl.sv
// Accumulation controller around add_wrapp: folds a word stream into one sum.
// Ports: in_data/in_rdy stream in, add_op_a/b/add_res adder loop, out_data/out_rdy result.
package add_acc_pkg;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned TYPE_W = 2;

  typedef struct packed {
    logic [WORD_W-1:0] data_word;
    logic              data_val;
    logic [TYPE_W-1:0] data_type;
    logic              data_last;
  } pipe_data_t;

  typedef enum logic [1:0] {
    FMT_FXP,
    FMT_FP
  } arith_fmt_e;

  typedef struct packed {
    arith_fmt_e fmt;
    logic [7:0] width;
    logic [7:0] frac;
    logic       satur;
  } arith_cfg_t;

  localparam arith_cfg_t ADD_CFG_DEF = '{
    fmt:   FMT_FXP,
    width: 8'd16,
    frac:  8'd8,
    satur: 1'b1
  };
endpackage

module add_acc_ctrl
  import add_acc_pkg::*;
#(
  parameter arith_cfg_t  ADD_ARITH_CFG   = ADD_CFG_DEF,
  parameter int unsigned ADD_IN_CYC_LEN  = 1,
  parameter int unsigned ADD_OUT_CYC_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  pipe_data_t in_data,
  output logic       in_rdy,
  output pipe_data_t add_op_a,
  output pipe_data_t add_op_b,
  input  pipe_data_t add_res,
  output pipe_data_t out_data,
  input  logic       out_rdy
);
  localparam int unsigned L  = ADD_IN_CYC_LEN + ADD_OUT_CYC_LEN;
  localparam int unsigned CW = $clog2(L + 1);

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    WAIT1,
    EMIT
  } state_e;

  if (ADD_ARITH_CFG.width != 8'(WORD_W) || L < 1) begin : g_bad_cfg
    $error("add_acc_ctrl: bad adder configuration");
  end

  state_e              state_q, state_d;
  cnt_t                live_q, live_d;
  cnt_t                flush_q, flush_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  pipe_data_t          out_q, out_d;
  logic                r;
  logic                unused_res;

  // Results still in the adder from before reset must not be merged.
  assign r          = add_res.data_val && (flush_q == '0);
  assign unused_res = ^{add_res.data_type, add_res.data_last};
  assign out_data   = out_q;

  always_comb begin
    state_d    = state_q;
    live_d     = live_q;
    flush_d    = flush_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    type_d     = type_q;
    out_d      = out_q;
    in_rdy     = 1'b0;
    add_op_a   = '0;
    add_op_b   = '0;
    if (flush_q != '0)
      flush_d = flush_q - cnt_t'(1);
    unique case (state_q)
      ACC: begin
        in_rdy = 1'b1;
        if (in_data.data_val) begin
          add_op_a.data_val  = 1'b1;
          add_op_a.data_type = in_data.data_type;
          if (r)
            add_op_a.data_word = add_res.data_word;
          add_op_b = in_data;
          if (!r)
            live_d = live_q + cnt_t'(1);
          if (live_q == '0)
            type_d = in_data.data_type;
          if (in_data.data_last)
            state_d = (L == 1) ? WAIT1 : DRAIN;
        end else if (r) begin
          // Keep a returning partial alive by adding zero to it.
          add_op_a.data_word = add_res.data_word;
          add_op_a.data_val  = 1'b1;
          add_op_a.data_type = type_q;
          add_op_b.data_val  = 1'b1;
          add_op_b.data_type = type_q;
        end
      end
      DRAIN: begin
        if (r) begin
          if (hold_vld_q) begin
            add_op_a.data_word = hold_q;
            add_op_a.data_val  = 1'b1;
            add_op_a.data_type = type_q;
            add_op_b.data_word = add_res.data_word;
            add_op_b.data_val  = 1'b1;
            add_op_b.data_type = type_q;
            hold_vld_d         = 1'b0;
            live_d             = live_q - cnt_t'(1);
          end else if (live_q > cnt_t'(1)) begin
            hold_d     = add_res.data_word;
            hold_vld_d = 1'b1;
          end else begin
            out_d = '{
              data_word: add_res.data_word,
              data_val:  1'b1,
              data_type: type_q,
              data_last: 1'b1
            };
            state_d = EMIT;
          end
        end
      end
      WAIT1: begin
        if (r) begin
          out_d = '{
            data_word: add_res.data_word,
            data_val:  1'b1,
            data_type: type_q,
            data_last: 1'b1
          };
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_rdy) begin
          out_d.data_val = 1'b0;
          live_d         = '0;
          state_d        = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      live_q     <= '0;
      flush_q    <= cnt_t'(L);
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      type_q     <= '0;
      out_q      <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      live_q     <= live_d;
      flush_q    <= flush_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      type_q     <= type_d;
      out_q      <= out_d;
    end
  end
endmodule

// File: tb/tb_add_acc_ctrl.sv
// Bench for add_acc_ctrl: three instances (L=1,2,3) each closed by a
// saturating 8.8 adder model; table vectors, hand sequences, random streams.
module tb_add_acc_ctrl;
  import add_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       rand_en = 1'b0;
  pipe_data_t in_d [3];
  pipe_data_t out_d [3];
  logic       rdy_in [3];
  logic       rdy_out [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  function automatic pipe_data_t sat_add(pipe_data_t a, pipe_data_t b);
    pipe_data_t o;
    int s;
    s = int'($signed(a.data_word)) + int'($signed(b.data_word));
    o = b;
    o.data_val = a.data_val & b.data_val;
    if (s > 32767)
      o.data_word = 16'h7FFF;
    else if (s < -32768)
      o.data_word = 16'h8000;
    else
      o.data_word = 16'(s);
    return o;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned LK = k + 1;
    pipe_data_t op_a, op_b;
    pipe_data_t pipe [LK];

    add_acc_ctrl #(
      .ADD_ARITH_CFG  (ADD_CFG_DEF),
      .ADD_IN_CYC_LEN (1),
      .ADD_OUT_CYC_LEN(LK - 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .in_data (in_d[k]),
      .in_rdy  (rdy_in[k]),
      .add_op_a(op_a),
      .add_op_b(op_b),
      .add_res (pipe[LK-1]),
      .out_data(out_d[k]),
      .out_rdy (rdy_out[k])
    );

    always @(posedge clk) begin
      if (clk_en) begin
        pipe[0] <= sat_add(op_a, op_b);
        for (int i = 1; i < int'(LK); i++)
          pipe[i] <= pipe[i-1];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum(input logic [15:0] w [$]);
    int s = 0;
    foreach (w[i]) s += int'($signed(w[i]));
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  task automatic rnd_en();
    if (rand_en) clk_en = ($urandom_range(0, 5) != 0);
  endtask

  // Caller sits at a negedge; returns with the last word driven.
  task automatic send_stream(input int k, input logic [15:0] w [$],
                             input logic [1:0] typ, input int gap);
    int t;
    for (int i = 0; i < w.size(); i++) begin
      in_d[k] = '{
        data_word: w[i],
        data_val:  1'b1,
        data_type: (i == 0) ? typ : ~typ,
        data_last: (i == w.size() - 1)
      };
      t = 0;
      while (!(rdy_in[k] && clk_en) && t < 200) begin
        @(negedge clk);
        rnd_en();
        t++;
      end
      if (t >= 200) chk("in_timeout", 1, 0);
      if (i == w.size() - 1) return;
      @(negedge clk);
      rnd_en();
      in_d[k] = '0;
      repeat (gap) begin
        @(negedge clk);
        rnd_en();
      end
    end
  endtask

  task automatic wait_out(input int k, input logic [15:0] exp,
                          input logic [1:0] typ, input int lat,
                          input int hold);
    int cyc = 0;
    bit bad_rdy = 0;
    bit got = 0;
    bit unstable = 0;
    pipe_data_t seen;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      rnd_en();
      in_d[k] = '0;
      cyc++;
      if (rdy_in[k]) bad_rdy = 1;
      if (out_d[k].data_val) got = 1;
    end
    chk("out_seen", 32'(got), 1);
    if (!got) return;
    chk("out_word", out_d[k].data_word, exp);
    chk("out_type", out_d[k].data_type, typ);
    chk("out_last", out_d[k].data_last, 1);
    chk("rdy_low_drain", 32'(bad_rdy), 0);
    if (lat != 0) chk("latency", cyc, lat);
    seen = out_d[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      // Alternate a frozen out_rdy=1 with plain stall cycles.
      clk_en = (i % 2 == 0);
      rdy_out[k] = !clk_en;
      if (out_d[k] !== seen || rdy_in[k]) unstable = 1;
    end
    if (hold != 0) chk("emit_stable", 32'(unstable), 0);
    @(negedge clk);
    if (out_d[k] !== seen) chk("emit_hold", out_d[k], seen);
    clk_en = 1'b1;
    rdy_out[k] = 1'b1;
    @(negedge clk);
    rdy_out[k] = 1'b0;
    chk("out_val_after_acc", out_d[k].data_val, 0);
    chk("rdy_after_acc", rdy_in[k], 1);
  endtask

  typedef struct packed {
    logic [1:0]       k;
    logic [3:0]       n;
    logic [7:0][15:0] w;
    logic [1:0]       typ;
    logic [1:0]       gap;
    logic [15:0]      exp;
    logic [2:0]       lat;
    logic [2:0]       hold;
  } vec_t;

  initial begin
    vec_t tbl [9];
    logic [15:0] q [$];
    tbl[0] = '{k: 1, n: 4, w: {64'h0, 64'h0400_0300_0200_0100}, typ: 1,
               gap: 0, exp: 16'h0A00, lat: 0, hold: 0};
    tbl[1] = '{k: 1, n: 4, w: {64'h0, 64'h0400_0300_0200_0100}, typ: 2,
               gap: 3, exp: 16'h0A00, lat: 0, hold: 0};
    tbl[2] = '{k: 0, n: 1, w: {112'h0, 16'h0300}, typ: 2,
               gap: 0, exp: 16'h0300, lat: 2, hold: 0};
    tbl[3] = '{k: 2, n: 8, w: {8{16'h0080}}, typ: 3,
               gap: 0, exp: 16'h0400, lat: 0, hold: 0};
    tbl[4] = '{k: 1, n: 2, w: {96'h0, 32'h6400_6400}, typ: 1,
               gap: 0, exp: 16'h7FFF, lat: 0, hold: 0};
    tbl[5] = '{k: 1, n: 3, w: {80'h0, 48'h0300_0200_0100}, typ: 0,
               gap: 0, exp: 16'h0600, lat: 0, hold: 5};
    tbl[6] = '{k: 1, n: 2, w: {96'h0, 32'hFF00_0100}, typ: 3,
               gap: 1, exp: 16'h0000, lat: 0, hold: 0};
    tbl[7] = '{k: 2, n: 2, w: {96'h0, 32'h8100_8100}, typ: 2,
               gap: 0, exp: 16'h8000, lat: 0, hold: 0};
    tbl[8] = '{k: 1, n: 1, w: {112'h0, 16'h1234}, typ: 1,
               gap: 0, exp: 16'h1234, lat: 0, hold: 0};

    for (int k = 0; k < 3; k++) begin
      in_d[k] = '0;
      rdy_out[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_rdy", rdy_in[k], 1);
      chk("rst_out", out_d[k], 0);
    end
    chk("rst_op_a_val", g_dut[1].op_a.data_val, 0);
    chk("rst_op_b_val", g_dut[1].op_b.data_val, 0);

    foreach (tbl[i]) begin
      q.delete();
      for (int j = 0; j < int'(tbl[i].n); j++) q.push_back(tbl[i].w[j]);
      send_stream(int'(tbl[i].k), q, tbl[i].typ, int'(tbl[i].gap));
      wait_out(int'(tbl[i].k), tbl[i].exp, tbl[i].typ, int'(tbl[i].lat),
               int'(tbl[i].hold));
    end

    // Reset in the middle of a drain, then a fresh stream.
    q = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_stream(1, q, 2'd1, 0);
    @(negedge clk);
    in_d[1] = '0;
    @(negedge clk);
    chk("drain_rdy_low", rdy_in[1], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_rdy", rdy_in[1], 1);
    chk("rst_mid_out_val", out_d[1].data_val, 0);
    q = '{16'h0100, 16'h0100};
    send_stream(1, q, 2'd2, 0);
    wait_out(1, 16'h0200, 2'd2, 0, 0);

    // Held word under clk_en=0 must not be taken.
    @(negedge clk);
    clk_en = 1'b0;
    in_d[1] = '{data_word: 16'h0700, data_val: 1'b1,
                data_type: 2'd3, data_last: 1'b1};
    repeat (3) @(negedge clk);
    chk("frozen_rdy", rdy_in[1], 1);
    chk("frozen_no_out", out_d[1].data_val, 0);
    clk_en = 1'b1;
    wait_out(1, 16'h0700, 2'd3, 0, 0);

    rand_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 10; s++) begin
        int n;
        logic [1:0] typ;
        n = $urandom_range(1, 8);
        typ = 2'($urandom_range(0, 3));
        q.delete();
        for (int j = 0; j < n; j++)
          q.push_back(16'(int'($urandom_range(0, 4095)) - 2048));
        send_stream(k, q, typ, $urandom_range(0, 2));
        wait_out(k, ref_sum(q), typ, 0, $urandom_range(0, 3));
      end
    end
    rand_en = 1'b0;
    clk_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
